// File: rtl/moldudp64_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : moldudp64_pkg
//  Description : Shared field widths, FSM encoding and lane helper for the
//                MoldUDP64 header parser.
//  Revision    : 1.0  initial release
// ============================================================================
package moldudp64_pkg;

    localparam int SESSION_W          = 80;
    localparam int SEQ_W              = 64;
    localparam int MSG_CNT_W          = 16;
    localparam int HDR_BYTES          = 20;
    localparam logic [15:0] MSG_CNT_EOS = 16'hFFFF;

    typedef enum logic [2:0] {
        H0      = 3'd0,
        H1      = 3'd1,
        H2      = 3'd2,
        PAYLOAD = 3'd3,
        DROP    = 3'd4
    } hdr_fsm_e;

    // Network byte k of a 64-bit beat (lane 0 sits in the top byte)
    function automatic logic [7:0] lane_byte(input logic [63:0] beat, input int k);
        return beat[63-8*k -: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/endian_flip.sv
`default_nettype none
// ============================================================================
//  Module      : endian_flip
//  Description : Reverses the byte order of a B-byte word.
//  Revision    : 1.0  initial release
// ============================================================================
module endian_flip #(
    parameter int B = 8
) (
    input  logic [8*B-1:0] in_i,
    output logic [8*B-1:0] out_o
);

    genvar i;
    generate
        for (i = 0; i < B; i++) begin : g_byte
            assign out_o[8*i +: 8] = in_i[8*(B-1-i) +: 8];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/moldudp64_header_parser.sv
`default_nettype none
// ============================================================================
//  Module      : moldudp64_header_parser
//  Description : Strips the 20-byte MoldUDP64 header from a 64-bit beat
//                stream, presents Session / Sequence / Message Count and
//                tracks the expected sequence number across packets.
//  Revision    : 1.0  initial release
// ============================================================================
module moldudp64_header_parser
    import moldudp64_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int KEEP_W    = 8,
    parameter int SEQ_CHECK = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DATA_W-1:0]    data_i,
    input  logic [KEEP_W-1:0]    keep_i,
    input  logic                 last_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DATA_W-1:0]    data_o,
    output logic [KEEP_W-1:0]    keep_o,
    output logic                 last_o,
    output logic                 hdr_v_o,
    output logic [SESSION_W-1:0] session_o,
    output logic [SEQ_W-1:0]     seq_o,
    output logic [MSG_CNT_W-1:0] msg_cnt_o,
    output logic                 heartbeat_o,
    output logic                 eos_o,
    output logic                 seq_gap_o,
    output logic                 hdr_err_o
);

    hdr_fsm_e               state_q, state_d;
    logic [63:0]            hold0_q, hold0_d, hold1_q, hold1_d;
    logic                   valid_q, valid_d, last_q, last_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [KEEP_W-1:0]      keep_q, keep_d;
    logic                   hdr_v_q, hdr_v_d, hdr_err_q, hdr_err_d;
    logic [SESSION_W-1:0]   session_q, session_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic [MSG_CNT_W-1:0]   msg_cnt_q, msg_cnt_d;

    logic                   w_accept;
    logic                   w_hdr_ok;
    logic [SEQ_W-1:0]       w_seq_raw, w_seq_host;
    logic [MSG_CNT_W-1:0]   w_cnt_raw, w_cnt_host;

    assign ready_o  = ~valid_q | ready_i;
    assign w_accept = valid_i & ready_o;

    // Gather field bytes in arrival order (byte 0 in the low byte) for flipping
    always_comb begin
        w_seq_raw = '0;
        for (int i = 0; i < 6; i++) begin
            w_seq_raw[8*i +: 8] = lane_byte(hold1_q, i + 2);
        end
        w_seq_raw[55:48] = lane_byte(data_i, 0);
        w_seq_raw[63:56] = lane_byte(data_i, 1);
        w_cnt_raw        = {lane_byte(data_i, 3), lane_byte(data_i, 2)};
    end

    endian_flip #(.B(8)) u_seq_flip (.in_i(w_seq_raw), .out_o(w_seq_host));
    endian_flip #(.B(2)) u_cnt_flip (.in_i(w_cnt_raw), .out_o(w_cnt_host));

    // Header FSM and output-stage next-state; advances on accepted beats only
    always_comb begin
        state_d   = state_q;
        hold0_d   = hold0_q;
        hold1_d   = hold1_q;
        valid_d   = valid_q & ~ready_i;
        data_d    = data_q;
        keep_d    = keep_q;
        last_d    = last_q;
        hdr_v_d   = 1'b0;
        hdr_err_d = 1'b0;
        session_d = session_q;
        seq_d     = seq_q;
        msg_cnt_d = msg_cnt_q;
        w_hdr_ok  = 1'b0;
        if (w_accept) begin
            case (state_q)
                H0: begin
                    if (keep_i == '1 && !last_i) begin
                        hold0_d = data_i;
                        state_d = H1;
                    end else begin
                        hdr_err_d = 1'b1;
                    end
                end
                H1: begin
                    if (keep_i == '1 && !last_i) begin
                        hold1_d = data_i;
                        state_d = H2;
                    end else begin
                        hdr_err_d = 1'b1;
                        state_d   = H0;
                    end
                end
                H2: begin
                    if (keep_i[7:4] == 4'hF) begin
                        w_hdr_ok  = 1'b1;
                        hdr_v_d   = 1'b1;
                        session_d = {hold0_q, hold1_q[63:48]};
                        seq_d     = w_seq_host;
                        msg_cnt_d = w_cnt_host;
                        // Header lanes are zeroed so nothing stale leaks downstream
                        if (keep_i[3:0] != 4'h0) begin
                            valid_d = 1'b1;
                            data_d  = {32'h0, data_i[31:0]};
                            keep_d  = {4'h0, keep_i[3:0]};
                            last_d  = last_i;
                        end
                        state_d = last_i ? H0 : PAYLOAD;
                    end else begin
                        hdr_err_d = 1'b1;
                        state_d   = last_i ? H0 : DROP;
                    end
                end
                PAYLOAD: begin
                    valid_d = 1'b1;
                    data_d  = data_i;
                    keep_d  = keep_i;
                    last_d  = last_i;
                    if (last_i) state_d = H0;
                end
                DROP: begin
                    if (last_i) state_d = H0;
                end
                default: state_d = H0;
            endcase
        end
    end

    // State, output stage and header field registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= H0;
            hold0_q   <= '0;
            hold1_q   <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            hdr_v_q   <= 1'b0;
            hdr_err_q <= 1'b0;
            session_q <= '0;
            seq_q     <= '0;
            msg_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hold0_q   <= hold0_d;
            hold1_q   <= hold1_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            last_q    <= last_d;
            hdr_v_q   <= hdr_v_d;
            hdr_err_q <= hdr_err_d;
            session_q <= session_d;
            seq_q     <= seq_d;
            msg_cnt_q <= msg_cnt_d;
        end
    end

    generate
        if (SEQ_CHECK != 0) begin : g_seq_check
            logic [SEQ_W-1:0] exp_q, exp_d;
            logic             exp_valid_q, exp_valid_d;
            logic             gap_q, gap_d;

            // Heartbeat and end-of-session packets do not advance the sequence
            always_comb begin
                exp_d       = exp_q;
                exp_valid_d = exp_valid_q;
                gap_d       = gap_q;
                if (w_hdr_ok) begin
                    gap_d       = exp_valid_q & (w_seq_host != exp_q);
                    exp_d       = w_seq_host +
                                  ((w_cnt_host == 16'h0 || w_cnt_host == MSG_CNT_EOS)
                                   ? 64'd0 : {48'd0, w_cnt_host});
                    exp_valid_d = 1'b1;
                end
            end

            // Expected-sequence tracker registers
            always_ff @(posedge clk) begin
                if (reset) begin
                    exp_q       <= '0;
                    exp_valid_q <= 1'b0;
                    gap_q       <= 1'b0;
                end else begin
                    exp_q       <= exp_d;
                    exp_valid_q <= exp_valid_d;
                    gap_q       <= gap_d;
                end
            end

            assign seq_gap_o = gap_q;
        end else begin : g_no_seq_check
            assign seq_gap_o = 1'b0;
        end
    endgenerate

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign keep_o      = keep_q;
    assign last_o      = last_q;
    assign hdr_v_o     = hdr_v_q;
    assign hdr_err_o   = hdr_err_q;
    assign session_o   = session_q;
    assign seq_o       = seq_q;
    assign msg_cnt_o   = msg_cnt_q;
    assign heartbeat_o = (msg_cnt_q == 16'h0);
    assign eos_o       = (msg_cnt_q == MSG_CNT_EOS);

endmodule
`default_nettype wire

// File: tb/tb_moldudp64_header_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_moldudp64_header_parser
//  Description : Self-checking bench with a byte-level packet reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_moldudp64_header_parser;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_i, ready_o, last_i, valid_o, ready_i, last_o;
    logic [63:0]  data_i, data_o;
    logic [7:0]   keep_i, keep_o;
    logic         hdr_v_o, heartbeat_o, eos_o, seq_gap_o, hdr_err_o;
    logic [79:0]  session_o;
    logic [63:0]  seq_o;
    logic [15:0]  msg_cnt_o;

    always #5 clk = ~clk;

    moldudp64_header_parser #(.DATA_W(64), .KEEP_W(8), .SEQ_CHECK(1)) dut (
        .clk(clk), .reset(reset),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .keep_i(keep_i), .last_i(last_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .keep_o(keep_o), .last_o(last_o),
        .hdr_v_o(hdr_v_o), .session_o(session_o), .seq_o(seq_o), .msg_cnt_o(msg_cnt_o),
        .heartbeat_o(heartbeat_o), .eos_o(eos_o), .seq_gap_o(seq_gap_o), .hdr_err_o(hdr_err_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct { logic [63:0] data; logic [7:0] keep; logic last; } beat_t;
    typedef struct { logic [79:0] session; logic [63:0] seq; logic [15:0] cnt; logic gap; } hdr_t;

    beat_t       exp_beats[$];
    hdr_t        exp_hdrs[$];
    int          exp_errs  = 0;
    int          seen_errs = 0;
    logic [63:0] m_exp_seq = '0;
    bit          m_exp_valid = 0;
    logic [7:0]  pkt [0:255];
    int          pkt_len;
    bit          stall = 0;
    int          rdy_pct = 100;
    bit          mon_en = 0;

    // Packet bytes: random ASCII session, big-endian seq and count, random payload
    task automatic build_pkt(input logic [63:0] seq, input logic [15:0] cnt, input int plen);
        for (int i = 0; i < 10; i++) pkt[i] = 8'(8'h41 + $urandom_range(0, 25));
        for (int i = 0; i < 8; i++)  pkt[10+i] = seq[63-8*i -: 8];
        pkt[18] = cnt[15:8];
        pkt[19] = cnt[7:0];
        for (int i = 0; i < plen; i++) pkt[20+i] = 8'($urandom);
        pkt_len = 20 + plen;
    endtask

    // Reference: header fields from bytes 0..19, payload byte p lands in
    // output beat p/8-2 at lane p%8
    task automatic model_good();
        hdr_t        h;
        logic [63:0] od [0:7];
        logic [7:0]  ok [0:7];
        int          nob;
        beat_t       b;
        h.seq = '0;
        for (int i = 0; i < 10; i++) h.session[79-8*i -: 8] = pkt[i];
        for (int i = 0; i < 8; i++)  h.seq = (h.seq << 8) | {56'd0, pkt[10+i]};
        h.cnt = {pkt[18], pkt[19]};
        h.gap = m_exp_valid && (h.seq != m_exp_seq);
        m_exp_seq   = h.seq + ((h.cnt == 16'h0 || h.cnt == 16'hFFFF) ? 64'd0 : {48'd0, h.cnt});
        m_exp_valid = 1;
        exp_hdrs.push_back(h);
        for (int i = 0; i < 8; i++) begin od[i] = '0; ok[i] = '0; end
        nob = 0;
        for (int p = 20; p < pkt_len; p++) begin
            od[p/8-2][63-8*(p%8) -: 8] = pkt[p];
            ok[p/8-2][7-(p%8)] = 1'b1;
            nob = p/8 - 1;
        end
        for (int i = 0; i < nob; i++) begin
            b.data = od[i]; b.keep = ok[i]; b.last = (i == nob-1);
            exp_beats.push_back(b);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int guard = 0;
        if ($urandom_range(0, 3) == 0) begin
            valid_i = 1'b0;
            repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        end
        valid_i = 1'b1; data_i = d; keep_i = k; last_i = l;
        do begin
            @(negedge clk);
            guard++;
        end while (!ready_o && guard < 200);
        if (!ready_o) chk("accept_wait", ready_o, 1'b1);
        @(posedge clk); #1;
        valid_i = 1'b0; data_i = '0; keep_i = '0; last_i = 1'b0;
    endtask

    task automatic drive_pkt(input bit mal);
        logic [63:0] d;
        logic [7:0]  k;
        int nb = (pkt_len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            d = '0; k = '0;
            for (int j = 0; j < 8; j++) begin
                if (8*b + j < pkt_len) begin
                    d[63-8*j -: 8] = pkt[8*b+j];
                    k[7-j] = 1'b1;
                end
            end
            if (mal && b == 2) k = 8'hE0;
            send_beat(d, k, b == nb-1);
        end
    endtask

    task automatic good_pkt(input logic [63:0] seq, input logic [15:0] cnt, input int plen);
        build_pkt(seq, cnt, plen);
        model_good();
        drive_pkt(0);
    endtask

    task automatic trunc_pkt(input int len);
        build_pkt({$urandom, $urandom}, 16'd1, 0);
        pkt_len = len;
        exp_errs++;
        drive_pkt(0);
    endtask

    task automatic mal_pkt(input int plen);
        build_pkt({$urandom, $urandom}, 16'd2, plen);
        exp_errs++;
        drive_pkt(1);
    endtask

    // Downstream ready: random acceptance unless a directed stall is active
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            ready_i = stall ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Output monitor: compares against the model queues between clock edges
    initial begin
        beat_t       b;
        hdr_t        h;
        bit          prev_stall = 0;
        logic [63:0] prev_data = '0;
        logic [7:0]  prev_keep = '0;
        logic        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("ready_o", ready_o, !valid_o || ready_i);
                if (prev_stall) begin
                    chk("hold_valid", valid_o, 1'b1);
                    chk("hold_data", data_o, prev_data);
                    chk("hold_keep", keep_o, prev_keep);
                    chk("hold_last", last_o, prev_last);
                end
                prev_stall = valid_o && !ready_i;
                prev_data = data_o; prev_keep = keep_o; prev_last = last_o;
                if (valid_o && ready_i) begin
                    chk("beat_expected", exp_beats.size() != 0, 1'b1);
                    if (exp_beats.size() != 0) begin
                        b = exp_beats.pop_front();
                        chk("data_o", data_o, b.data);
                        chk("keep_o", keep_o, b.keep);
                        chk("last_o", last_o, b.last);
                    end
                end
                if (hdr_v_o) begin
                    chk("hdr_expected", exp_hdrs.size() != 0, 1'b1);
                    if (exp_hdrs.size() != 0) begin
                        h = exp_hdrs.pop_front();
                        chk("session_o", session_o, h.session);
                        chk("seq_o", seq_o, h.seq);
                        chk("msg_cnt_o", msg_cnt_o, h.cnt);
                        chk("heartbeat_o", heartbeat_o, h.cnt == 16'h0);
                        chk("eos_o", eos_o, h.cnt == 16'hFFFF);
                        chk("seq_gap_o", seq_gap_o, h.gap);
                    end
                end
                if (hdr_err_o) seen_errs++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset = 1'b1; valid_i = 1'b0; data_i = '0; keep_i = '0; last_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_o", valid_o, 1'b0);
        chk("rst_last_o", last_o, 1'b0);
        chk("rst_hdr_v_o", hdr_v_o, 1'b0);
        chk("rst_hdr_err_o", hdr_err_o, 1'b0);
        chk("rst_data_o", data_o, 64'd0);
        chk("rst_keep_o", keep_o, 8'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1;

        // 24-byte packet: seq 1, count 3, payload AABBCCDD in the header's last beat
        build_pkt(64'd1, 16'd3, 4);
        pkt[20] = 8'hAA; pkt[21] = 8'hBB; pkt[22] = 8'hCC; pkt[23] = 8'hDD;
        model_good();
        drive_pkt(0);
        // Bare heartbeat at the expected seq, then the same seq again
        good_pkt(64'd4, 16'd0, 0);
        good_pkt(64'd4, 16'd2, 10);
        // Gap: seq 10 count 2 followed by seq 13
        good_pkt(64'd10, 16'd2, 6);
        good_pkt(64'd13, 16'd1, 3);
        // Truncated in H1, then a clean packet
        trunc_pkt(12);
        good_pkt(64'd14, 16'd5, 17);
        // Downstream stall for three cycles in the middle of a long payload
        rdy_pct = 100;
        fork
            good_pkt(64'd19, 16'd7, 40);
            begin
                repeat (7) @(negedge clk);
                stall = 1;
                repeat (3) @(negedge clk);
                stall = 0;
            end
        join
        // Sequence wrap, then end-of-session
        good_pkt(64'hFFFF_FFFF_FFFF_FFFE, 16'd3, 8);
        good_pkt(64'd1, 16'hFFFF, 3);
        good_pkt(64'd1, 16'd4, 12);
        trunc_pkt(8);
        trunc_pkt(18);
        mal_pkt(12);

        // Randomized traffic with backpressure
        rdy_pct = 70;
        for (int n = 0; n < 40; n++) begin
            int r = $urandom_range(0, 9);
            if (r == 0) begin
                trunc_pkt($urandom_range(1, 19));
            end else if (r == 1) begin
                mal_pkt($urandom_range(5, 30));
            end else begin
                logic [63:0] s;
                logic [15:0] c;
                s = ($urandom_range(0, 2) != 0) ? m_exp_seq : {$urandom, $urandom};
                case ($urandom_range(0, 5))
                    0:       c = 16'h0;
                    1:       c = 16'hFFFF;
                    default: c = 16'($urandom);
                endcase
                good_pkt(s, c, $urandom_range(0, 36));
            end
        end

        rdy_pct = 100;
        guard = 0;
        while ((exp_beats.size() != 0 || exp_hdrs.size() != 0) && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("beats_drained", exp_beats.size(), 0);
        chk("hdrs_drained", exp_hdrs.size(), 0);
        chk("hdr_err_count", seen_errs, exp_errs);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
